// File: rtl/rr_arb_pkg.sv
// Shared types and limits for the round-robin grant arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ_MAX = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after last_owner+1, with wrap.
module rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_owner_i,
  output logic [ID_W-1:0]  pick_o,
  output logic             any_o
);

  localparam int unsigned SW = ID_W + 1;

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SW-1:0]      base;
  logic [SW-1:0]      sum;
  logic [ID_W-1:0]    k;
  logic               found;

  // Doubling the vector turns the cyclic search into a plain shift plus
  // lowest-set-bit search; the offset is added back modulo N_REQ.
  always_comb begin
    dbl   = {req_i, req_i};
    base  = SW'(last_owner_i) + SW'(1);
    rot   = N_REQ'(dbl >> base);
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        k     = ID_W'(i);
      end
    end
    sum = base + SW'(k);
    if (sum >= SW'(N_REQ)) begin
      sum = sum - SW'(N_REQ);
    end
    pick_o = ID_W'(sum);
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with held grants and a one-cycle release turnaround.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int unsigned N_REQ    = 4,
  parameter  int unsigned MAX_HOLD = 16,
  localparam int unsigned ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             timeout
);

  localparam logic [N_REQ-1:0] GNT_LSB = N_REQ'(1);

  if (N_REQ < 2 || N_REQ > N_REQ_MAX || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_grant_arbiter: unsupported N_REQ or MAX_HOLD");
  end

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic [ID_W-1:0]  last_owner_q;
  logic [ID_W-1:0]  pick;
  logic             any;
  logic             rel_owner;
  logic             expire;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .pick_o       (pick),
    .any_o        (any)
  );

  // Only the current owner's done/req bits can end a grant.
  assign rel_owner = done[gnt_id_q] | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);

  logic [HC_W-1:0] hold_cnt_q;
  logic            timeout_q;

  assign expire = (hold_cnt_q == HC_W'(MAX_HOLD - 1));

  // A release by the owner on the expiry cycle is not reported as a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= (state_q == GRANT) && expire && !rel_owner;
      if (state_q != GRANT) begin
        hold_cnt_q <= '0;
      end else if (!(rel_owner || expire)) begin
        hold_cnt_q <= hold_cnt_q + HC_W'(1);
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      last_owner_q <= ID_W'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            state_q      <= GRANT;
            gnt_q        <= GNT_LSB << pick;
            gnt_id_q     <= pick;
            last_owner_q <= pick;
          end
        end
        GRANT: begin
          if (rel_owner || expire) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N_REQ=4, MAX_HOLD=16).
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  rr_grant_arbiter #(.N_REQ(4), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'hF;
    done  = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, gnt_valid, gnt_id, timeout} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: gnt=%b valid=%b id=%0d timeout=%b required all zero",
               gnt, gnt_valid, gnt_id, timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant: gnt=%b id=%0d valid=%b required 0001/0/1",
               gnt, gnt_id, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_id;
    logic [3:0] exp_g;
    for (int k = 0; k < 5; k++) begin
      exp_id = 2'(k % 4);
      exp_g  = 4'b0001 << exp_id;
      checks++;
      if (gnt !== exp_g || gnt_id !== exp_id || gnt_valid !== 1'b1) begin
        failures++;
        $display("FAIL rotation_grant[%0d]: gnt=%b id=%0d required %b/%0d", k, gnt, gnt_id, exp_g, exp_id);
      end
      if (k == 4) break;
      @(negedge clk);
      checks++;
      if (gnt !== exp_g) begin
        failures++;
        $display("FAIL rotation_hold[%0d]: gnt=%b required %b", k, gnt, exp_g);
      end
      done = exp_g;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== exp_id) begin
        failures++;
        $display("FAIL rotation_release[%0d]: gnt=%b valid=%b id=%0d required 0000/0/%0d",
                 k, gnt, gnt_valid, gnt_id, exp_id);
      end
      done = 4'h0;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000) begin
        failures++;
        $display("FAIL rotation_idle[%0d]: gnt=%b required 0000", k, gnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ownership();
    rst_n = 1'b0;
    req   = 4'b0100;
    done  = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      failures++;
      $display("FAIL own_setup: gnt=%b id=%0d required 0100/2", gnt, gnt_id);
    end
    req  = 4'hF;
    done = 4'b0010;
    @(negedge clk);
    done = 4'h0;
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL own_foreign_done: gnt=%b required 0100", gnt);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL own_foreign_done_hold: gnt=%b required 0100", gnt);
    end
    req = 4'b1011;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd2) begin
      failures++;
      $display("FAIL own_drop_release: gnt=%b valid=%b id=%0d required 0000/0/2", gnt, gnt_valid, gnt_id);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL own_drop_idle: gnt=%b required 0000", gnt);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      failures++;
      $display("FAIL own_next_grant: gnt=%b id=%0d required 1000/3", gnt, gnt_id);
    end
  endtask

  task automatic test_drop_same_cycle();
    done = 4'b1000;
    @(negedge clk);
    done = 4'h0;
    req  = 4'h0;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    req = 4'h0;
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL drop_granted: gnt=%b id=%0d required 0001/0", gnt, gnt_id);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000) begin
        failures++;
        $display("FAIL drop_released[%0d]: gnt=%b required 0000", i, gnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    req  = 4'b0010;
    done = 4'b0010;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_g = (i % 3 == 0) ? 4'b0010 : 4'b0000;
      checks++;
      if (gnt !== exp_g) begin
        failures++;
        $display("FAIL back_to_back[%0d]: gnt=%b required %b", i, gnt, exp_g);
      end
    end
    req  = 4'h0;
    done = 4'h0;
  endtask

  task automatic test_hold();
    int n_hi;
    int bad;
    req = 4'b1000;
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    n_hi = 0;
    bad  = 0;
    while (gnt === 4'b1000 && n_hi < 40) begin
      if (timeout !== 1'b0) bad++;
      n_hi++;
      @(negedge clk);
    end
    checks++;
    if (n_hi != 16 || bad != 0) begin
      failures++;
      $display("FAIL timeout_hold_len: held=%0d early_pulses=%0d required 16/0", n_hi, bad);
    end
    checks++;
    if (timeout !== 1'b1 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_pulse: timeout=%b gnt=%b required 1/0000", timeout, gnt);
    end
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_single: timeout=%b required 0", timeout);
    end
`else
    n_hi = 0;
    bad  = 0;
    for (int c = 0; c < 120; c++) begin
      if (gnt === 4'b1000 && timeout === 1'b0) n_hi++;
      else bad++;
      @(negedge clk);
    end
    checks++;
    if (n_hi != 120 || bad != 0) begin
      failures++;
      $display("FAIL hold_forever: held=%0d bad=%0d required 120/0", n_hi, bad);
    end
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: gnt=%b timeout=%b required 0000/0", gnt, timeout);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL midrst_setup: gnt=%b required 0100", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL midrst_async: gnt=%b valid=%b id=%0d required 0000/0/0", gnt, gnt_valid, gnt_id);
    end
    req = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL midrst_restart: gnt=%b id=%0d required 0001/0", gnt, gnt_id);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (!$onehot0(gnt) || gnt_valid !== (|gnt) ||
          (gnt_valid && gnt !== (4'b0001 << gnt_id)) || (timeout && gnt_valid)) begin
        failures++;
        $display("FAIL random_invariant[%0d]: gnt=%b valid=%b id=%0d timeout=%b",
                 c, gnt, gnt_valid, gnt_id, timeout);
      end
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    req  = 4'h0;
    done = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'h0;
    done  = 4'h0;
    test_reset();
    test_rotation();
    test_ownership();
    test_drop_same_cycle();
    test_back_to_back();
    test_hold();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
